// File: rtl/fpga_to_dsp_int_pkg.sv
// Shared types and default widths for the FPGA-to-DSP interface block.
package fpga_to_dsp_int_pkg;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDWidth    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } addr_state_e;

endpackage

// File: rtl/fpga_to_dsp_addr_gen.sv
// Burst address generator: emits BurstLen sequential addresses from 0, then a one-cycle Done.
module fpga_to_dsp_addr_gen
  import fpga_to_dsp_int_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] burst_len_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 addr_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  addr_state_e          state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  // Beats remaining after the current one; BurstLen=0 wraps to all-ones, i.e. 2^AddrWidth beats.
  logic [AddrWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = '0;
          cnt_d   = burst_len_i - AddrWidth'(1);
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          addr_d = addr_q + AddrWidth'(1);
          cnt_d  = cnt_q - AddrWidth'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = (state_q == StRun);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);

endmodule

// File: rtl/fpga_to_dsp_int.sv
// FPGA-to-DSP interface: burst address generator plus a single-entry capture register.
module fpga_to_dsp_int
  import fpga_to_dsp_int_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DWidth    = DefDWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] burst_len_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 addr_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [DWidth-1:0]    din_i,
  input  logic                 din_valid_i,
  output logic [DWidth-1:0]    data_o,
  output logic                 data_valid_o,
  input  logic                 data_ack_i,
  output logic                 overflow_o
);

  fpga_to_dsp_addr_gen #(
    .AddrWidth(AddrWidth)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .addr_o      (addr_o),
    .addr_valid_o(addr_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  logic [DWidth-1:0] data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              overflow_q, overflow_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overflow_d   = overflow_q;
    if (data_ack_i) begin
      data_valid_d = 1'b0;
    end
    if (din_valid_i) begin
      data_d       = din_i;
      data_valid_d = 1'b1;
      // Only an unacknowledged entry counts as lost.
      if (data_valid_q && !data_ack_i) begin
        overflow_d = 1'b1;
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fpga_to_dsp_int.sv
// Directed bench: address beats checked against a scoreboard queue, data path against constants.
module tb_fpga_to_dsp_int;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  burst_len_i;
  logic [7:0]  addr_o;
  logic        addr_valid_o, busy_o, done_o;
  logic [7:0]  din_i, data_o;
  logic        din_valid_i, data_valid_o, data_ack_i, overflow_o;

  logic        start_w;
  logic [7:0]  burst_len_w;
  logic [7:0]  addr_w;
  logic        addr_valid_w, busy_w, done_w;
  logic [15:0] din_w, data_w;
  logic        din_valid_w, data_valid_w, data_ack_w, overflow_w;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned done_seen = 0;
  logic [7:0]  exp_q[$];

  always #5 clk_i = ~clk_i;

  fpga_to_dsp_int #(
    .AddrWidth(8),
    .DWidth   (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .addr_o      (addr_o),
    .addr_valid_o(addr_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .din_i       (din_i),
    .din_valid_i (din_valid_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .data_ack_i  (data_ack_i),
    .overflow_o  (overflow_o)
  );

  fpga_to_dsp_int #(
    .AddrWidth(8),
    .DWidth   (16)
  ) dut_w (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_w),
    .burst_len_i (burst_len_w),
    .addr_o      (addr_w),
    .addr_valid_o(addr_valid_w),
    .busy_o      (busy_w),
    .done_o      (done_w),
    .din_i       (din_w),
    .din_valid_i (din_valid_w),
    .data_o      (data_w),
    .data_valid_o(data_valid_w),
    .data_ack_i  (data_ack_w),
    .overflow_o  (overflow_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1ns after the edge and scores any address beat or Done pulse.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk_i);
    #1;
    if (done_o) begin
      done_seen++;
      chk("done_addr_valid", {31'b0, addr_valid_o}, 32'd0);
    end
    if (addr_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("addr_spurious_valid", {31'b0, addr_valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("addr", {24'b0, addr_o}, {24'b0, e});
      end
    end
  endtask

  task automatic push_burst(input int unsigned n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
  endtask

  task automatic finish_burst(input string tag, input logic [7:0] last_addr);
    for (int i = 0; i < 400 && busy_o; i++) tick();
    chk({tag, "_busy_end"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_done_pulses"}, done_seen, 32'd1);
    chk({tag, "_beats_left"}, exp_q.size(), 32'd0);
    chk({tag, "_addr_hold"}, {24'b0, addr_o}, {24'b0, last_addr});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, {24'b0, addr_o}, 32'd0);
    chk({tag, "_ctrl"}, {28'b0, addr_valid_o, busy_o, done_o, data_valid_o}, 32'd0);
    chk({tag, "_data"}, {24'b0, data_o}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, overflow_o}, 32'd0);
    chk({tag, "_w_data"}, {16'b0, data_w}, 32'd0);
    chk({tag, "_w_flags"}, {30'b0, data_valid_w, overflow_w}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0; burst_len_i = 8'd0; din_i = 8'd0; din_valid_i = 1'b0; data_ack_i = 1'b0;
    start_w = 1'b0; burst_len_w = 8'd0; din_w = 16'd0; din_valid_w = 1'b0; data_ack_w = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_ni = 1'b1;

    // Burst of 4 with Start held into RUN, which must be ignored.
    burst_len_i = 8'd4;
    start_i = 1'b1;
    push_burst(4);
    done_seen = 0;
    tick();
    chk("burst4_busy", {31'b0, busy_o}, 32'd1);
    tick();
    start_i = 1'b0;
    finish_burst("burst4", 8'd3);

    // Zero length means a full 256-address sweep.
    burst_len_i = 8'd0;
    start_i = 1'b1;
    push_burst(256);
    done_seen = 0;
    tick();
    start_i = 1'b0;
    finish_burst("burst256", 8'd255);

    // Capture and acknowledge.
    din_i = 8'hA5; din_valid_i = 1'b1;
    din_w = 16'hBEEF; din_valid_w = 1'b1;
    tick();
    din_valid_i = 1'b0; din_valid_w = 1'b0;
    chk("cap_data", {24'b0, data_o}, 32'hA5);
    chk("cap_valid", {31'b0, data_valid_o}, 32'd1);
    chk("wide_data", {16'b0, data_w}, 32'hBEEF);
    chk("wide_valid", {31'b0, data_valid_w}, 32'd1);
    data_ack_i = 1'b1;
    tick();
    data_ack_i = 1'b0;
    chk("ack_valid", {31'b0, data_valid_o}, 32'd0);
    chk("ack_ovf", {31'b0, overflow_o}, 32'd0);
    tick();
    chk("ack_idle_valid", {31'b0, data_valid_o}, 32'd0);

    // Back-to-back writes without ack overflow.
    din_i = 8'h11; din_valid_i = 1'b1;
    tick();
    din_i = 8'h22;
    tick();
    din_valid_i = 1'b0;
    chk("ovf_data", {24'b0, data_o}, 32'h22);
    chk("ovf_flag", {31'b0, overflow_o}, 32'd1);
    data_ack_i = 1'b1;
    tick();
    data_ack_i = 1'b0;
    chk("ovf_sticky", {31'b0, overflow_o}, 32'd1);

    // Reset at Addr=2 of a 4-beat burst.
    burst_len_i = 8'd4;
    start_i = 1'b1;
    push_burst(4);
    done_seen = 0;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10 && !(addr_valid_o && addr_o == 8'd2); i++) tick();
    chk("abort_at_addr2", {24'b0, addr_o}, 32'd2);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("abort");
    exp_q.delete();
    repeat (2) tick();
    chk("abort_no_done", done_seen, 32'd0);

    // Restart on the first edge after release, data path active during the burst.
    rst_ni = 1'b1;
    start_i = 1'b1;
    push_burst(4);
    din_i = 8'h11; din_valid_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart_busy", {31'b0, busy_o}, 32'd1);
    din_i = 8'h22; data_ack_i = 1'b1;
    tick();
    din_valid_i = 1'b0; data_ack_i = 1'b0;
    chk("ackovf_data", {24'b0, data_o}, 32'h22);
    chk("ackovf_valid", {31'b0, data_valid_o}, 32'd1);
    chk("ackovf_flag", {31'b0, overflow_o}, 32'd0);
    finish_burst("restart", 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_to_dsp_int.md
FPGA_TO_DSP_INT -- requirements
Module: fpga_to_dsp_int

Interface
REQ-001 Parameter AddrWidth, default 8, width of the address bus and of the burst-length input.
REQ-002 Parameter DWidth, default 8, width of the data bus; the block SHALL work for DWidth=16 with no other change.
REQ-003 Clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 RstN  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  FPGA-side request to begin an address burst.
REQ-006 BurstLen  input  AddrWidth  number of addresses in a burst; 0 means 2^AddrWidth.
REQ-007 Addr  output  AddrWidth  generated address.
REQ-008 AddrValid  output  1  Addr is valid this cycle.
REQ-009 Busy  output  1  address generator is not idle.
REQ-010 Done  output  1  one-cycle pulse after the last address of a burst.
REQ-011 DIn  input  DWidth  DSP-side write data.
REQ-012 DInValid  input  1  DIn is valid this cycle.
REQ-013 Data  output  DWidth  captured data held for the FPGA.
REQ-014 DataValid  output  1  Data holds unconsumed data.
REQ-015 DataAck  input  1  FPGA consumes Data.
REQ-016 Overflow  output  1  sticky flag: unconsumed data was overwritten.

Function
REQ-017 Address FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE, Start=1 SHALL latch BurstLen and move to RUN on the next edge, with Addr=0 and AddrValid=1 in the first RUN cycle (latency 1 cycle).
REQ-019 In RUN, Addr SHALL increment by 1 per cycle, wrapping modulo 2^AddrWidth; after exactly the latched burst length the FSM SHALL enter DONE.
REQ-020 DONE SHALL last one cycle with Done=1 and AddrValid=0, then return to IDLE.
REQ-021 Start SHALL be ignored while in RUN or DONE.
REQ-022 Busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-023 In IDLE and DONE, Addr SHALL hold its last value.
REQ-024 DInValid=1 SHALL load DIn into Data and set DataValid on the next edge.
REQ-025 DataAck=1 while DataValid=1 SHALL clear DataValid on the next edge; DataAck while DataValid=0 SHALL have no effect.
REQ-026 If DInValid=1 and DataValid=1 with DataAck=0 in the same cycle, new data SHALL overwrite Data and Overflow SHALL set.
REQ-027 If DInValid=1 and DataAck=1 in the same cycle, new data SHALL load, DataValid SHALL stay 1, and Overflow SHALL NOT set.
REQ-028 Overflow SHALL clear only on reset.
REQ-029 The address path and the data path SHALL be independent; either SHALL operate while the other is active.

Reset
REQ-030 While RstN=0, all outputs SHALL be 0 (Addr=0, AddrValid=0, Busy=0, Done=0, Data=0, DataValid=0, Overflow=0) and the FSM SHALL be IDLE.
REQ-031 Assertion of RstN mid-burst SHALL abort the burst immediately with no Done pulse.
REQ-032 After release, the first Start SHALL be honored on the first clock edge.

Structure
REQ-033 The FSM state enum SHALL be defined in a shared package fpga_to_dsp_int_pkg, together with the default width constants.
REQ-034 The address generator SHALL be a sub-module named fpga_to_dsp_addr_gen; the data register SHALL be inline.

Verification
REQ-035 Address burst: BurstLen=4, Start pulse -> Addr 0,1,2,3 with AddrValid=1, then Done=1 for one cycle, Busy=0 after.
REQ-036 Zero-length burst: BurstLen=0 with AddrWidth=8 -> 256 addresses 0..255, then Done.
REQ-037 Data capture: DInValid with DIn=0xA5 -> Data=0xA5 and DataValid=1 next cycle; DataAck -> DataValid=0.
REQ-038 Overflow: two DInValid cycles (0x11 then 0x22) with no DataAck -> Data=0x22 and Overflow=1; same sequence with DataAck on the second cycle -> Overflow=0.
REQ-039 Wide data: DWidth=16, DIn=0xBEEF -> Data=0xBEEF.
REQ-040 Reset abort: RstN=0 at Addr=2 of a 4-address burst -> all outputs 0, no Done pulse; a new Start after release restarts at Addr=0.
